// File: rtl/ingress_pkg.sv
// ingress_pkg: shared types and TLP header/sideband field positions for the RX TLP router
package ingress_pkg;
    typedef enum logic [1:0] {TLP_MEM, TLP_CPL, TLP_UNSUP} tlp_class_e;
    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} route_state_e;
    localparam int FMT_LSB = 29;
    localparam int TYPE_LSB = 24;
    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;
    localparam int USER_ERR_BIT = 1;
    localparam int USER_BAR_LSB = 2;
    localparam int NUM_BAR = 7;
endpackage

// File: rtl/ingress_tlp_router_if.sv
// ingress_tlp_router_if: RX AXIS input and per-channel output bundle of the TLP router
interface ingress_tlp_router_if #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8,
    parameter int RX_USER_W = 22,
    parameter int NUM_CH = 3
);
    logic s_rx_tready;
    logic [DATA_W-1:0] s_rx_tdata;
    logic [KEEP_W-1:0] s_rx_tkeep;
    logic s_rx_tlast;
    logic s_rx_tvalid;
    logic [RX_USER_W-1:0] s_rx_tuser;
    logic [NUM_CH-1:0] m_tready;
    logic [NUM_CH-1:0] m_tvalid;
    logic [NUM_CH*DATA_W-1:0] m_tdata;
    logic [NUM_CH*KEEP_W-1:0] m_tkeep;
    logic [NUM_CH-1:0] m_sop;
    logic [NUM_CH-1:0] m_eop;
    logic [NUM_CH*8-1:0] m_tuser;
    modport master (
        output s_rx_tready, m_tvalid, m_tdata, m_tkeep, m_sop, m_eop, m_tuser,
        input s_rx_tdata, s_rx_tkeep, s_rx_tlast, s_rx_tvalid, s_rx_tuser, m_tready
    );
    modport slave (
        input s_rx_tready, m_tvalid, m_tdata, m_tkeep, m_sop, m_eop, m_tuser,
        output s_rx_tdata, s_rx_tkeep, s_rx_tlast, s_rx_tvalid, s_rx_tuser, m_tready
    );
endinterface

// File: rtl/ingress_tlp_classify.sv
// ingress_tlp_classify: maps header DW0 and BAR hit of a first beat to class, destination and drop flag
module ingress_tlp_classify
    import ingress_pkg::*;
#(
    parameter int CH_W = 2,
    parameter int CPL_CH = 1,
    parameter logic [NUM_BAR*CH_W-1:0] BAR_CH_MAP = {NUM_BAR{CH_W'(2)}},
    parameter logic [NUM_BAR-1:0] BAR_EN = 7'b0000001
) (
    input  logic [31:0] dw0_i,
    input  logic [NUM_BAR-1:0] bar_hit_i,
    output tlp_class_e cls_o,
    output logic [CH_W-1:0] dest_o,
    output logic drop_o
);
    logic [4:0] typ;
    logic [2:0] bar;
    logic unused_dw0;
    assign typ = dw0_i[TYPE_LSB+:5];
    assign unused_dw0 = ^{dw0_i[31], dw0_i[FMT_LSB+:2], dw0_i[TYPE_LSB-1:0]};
    // descending scan so the lowest set BAR wins
    always_comb begin
        bar = '0;
        for (int i = NUM_BAR - 1; i >= 0; i--)
            if (bar_hit_i[i]) bar = 3'(i);
    end
    always_comb begin
        cls_o = typ == TYPE_CPL ? TLP_CPL : typ == TYPE_MEM ? TLP_MEM : TLP_UNSUP;
        drop_o = cls_o == TLP_UNSUP || (cls_o == TLP_MEM && !(|bar_hit_i && BAR_EN[bar]));
        dest_o = cls_o == TLP_CPL ? CH_W'(CPL_CH) : BAR_CH_MAP[int'(bar)*CH_W+:CH_W];
    end
endmodule

// File: rtl/ingress_tlp_router.sv
// ingress_tlp_router: classifies RX TLPs on their first beat and forwards whole packets to one of NUM_CH channels
module ingress_tlp_router
    import ingress_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8,
    parameter int RX_USER_W = 22,
    parameter int NUM_CH = 3,
    parameter int CH_W = $clog2(NUM_CH),
    parameter int CPL_CH = 1,
    parameter logic [NUM_BAR*CH_W-1:0] BAR_CH_MAP = {NUM_BAR{CH_W'(2)}},
    parameter logic [NUM_BAR-1:0] BAR_EN = 7'b0000001,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    ingress_tlp_router_if.master bus,
    output logic [CNT_W-1:0] drop_cnt
);
    route_state_e state_q, state_d;
    logic vld_q, vld_d, sop_q, eop_q, err_q, err_d;
    logic [CH_W-1:0] dest_q, dest_d, cls_dest;
    logic [NUM_BAR-1:0] bar_q, bar_d;
    logic [NUM_CH-1:0][DATA_W-1:0] data_q;
    logic [NUM_CH-1:0][KEEP_W-1:0] keep_q;
    logic [NUM_CH-1:0][7:0] user_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tlp_class_e cls;
    logic cls_drop, sop, acc, fwd;
    logic unused_user;
    assign unused_user = ^{cls, bus.s_rx_tuser[0], bus.s_rx_tuser[RX_USER_W-1:USER_BAR_LSB+NUM_BAR]};
    ingress_tlp_classify #(
        .CH_W(CH_W), .CPL_CH(CPL_CH), .BAR_CH_MAP(BAR_CH_MAP), .BAR_EN(BAR_EN)
    ) u_classify (
        .dw0_i(bus.s_rx_tdata[31:0]),
        .bar_hit_i(bus.s_rx_tuser[USER_BAR_LSB+:NUM_BAR]),
        .cls_o(cls),
        .dest_o(cls_dest),
        .drop_o(cls_drop)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (acc) state_d = bus.s_rx_tlast ? ST_IDLE : !sop ? state_q : cls_drop ? ST_DROP : ST_PASS;
    end
    // ready only looks at the slot and downstream ready, never at s_rx_tvalid
    always_comb begin
        sop = state_q == ST_IDLE;
        bus.s_rx_tready = !rst && (state_q == ST_DROP || !vld_q || bus.m_tready[dest_q]);
        acc = bus.s_rx_tvalid && bus.s_rx_tready;
        fwd = acc && (state_q == ST_PASS || (sop && !cls_drop));
        for (int i = 0; i < NUM_CH; i++) begin
            bus.m_tvalid[i] = vld_q && dest_q == CH_W'(i);
            bus.m_sop[i] = vld_q && dest_q == CH_W'(i) && sop_q;
            bus.m_eop[i] = vld_q && dest_q == CH_W'(i) && eop_q;
        end
    end
    always_comb begin
        vld_d = fwd || (vld_q && !bus.m_tready[dest_q]);
        dest_d = sop ? cls_dest : dest_q;
        err_d = bus.s_rx_tuser[USER_ERR_BIT] || (!sop && err_q);
        bar_d = sop ? bus.s_rx_tuser[USER_BAR_LSB+:NUM_BAR] : bar_q;
        cnt_d = cnt_q + CNT_W'(acc && sop && cls_drop && cnt_q != '1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            err_q <= 1'b0;
            bar_q <= '0;
            dest_q <= '0;
            data_q <= '0;
            keep_q <= '0;
            user_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            if (fwd) begin
                dest_q <= dest_d;
                sop_q <= sop;
                eop_q <= bus.s_rx_tlast;
                err_q <= err_d;
                bar_q <= bar_d;
                data_q[dest_d] <= bus.s_rx_tdata;
                keep_q[dest_d] <= bus.s_rx_tkeep;
                user_q[dest_d] <= {err_d, bar_d};
            end
        end
    end
    assign bus.m_tdata = data_q;
    assign bus.m_tkeep = keep_q;
    assign bus.m_tuser = user_q;
    assign drop_cnt = cnt_q;
endmodule

// File: tb/tb_ingress_tlp_router.sv
// tb_ingress_tlp_router: table-driven and scoreboard-checked bench for the RX TLP router
module tb_ingress_tlp_router;
    localparam int DW = 128;
    localparam int KW = 16;
    localparam int UW = 22;
    localparam int NCH = 3;
    typedef struct {
        int ch;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic sop;
        logic eop;
        logic [7:0] user;
        int cyc;
        bit lat;
    } beat_t;
    typedef struct {
        logic [31:0] dw0;
        logic [6:0] bar;
        int nb;
        int ch;
        int err_beat;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] drop_cnt;
    int asserts = 0;
    int fails = 0;
    int cyc = 0;
    int model_cnt = 0;
    beat_t sb[$];
    beat_t e;
    vec_t vt[13];
    ingress_tlp_router_if #(.DATA_W(DW), .KEEP_W(KW), .RX_USER_W(UW), .NUM_CH(NCH)) bus ();
    ingress_tlp_router dut (.clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // output monitor: every channel handshake pops and checks one expected beat
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (bus.m_tvalid[i] && bus.m_tready[i]) begin
                chk("tvalid_onehot", DW'($countones(bus.m_tvalid)), DW'(1));
                if (sb.size() == 0) chk("unexpected_beat", DW'(i), '1);
                else begin
                    e = sb.pop_front();
                    chk("out_ch", DW'(i), DW'(e.ch));
                    chk("out_data", bus.m_tdata[i*DW+:DW], e.data);
                    chk("out_keep", DW'(bus.m_tkeep[i*KW+:KW]), DW'(e.keep));
                    chk("out_sop", DW'(bus.m_sop[i]), DW'(e.sop));
                    chk("out_eop", DW'(bus.m_eop[i]), DW'(e.eop));
                    chk("out_user", DW'(bus.m_tuser[i*8+:8]), DW'(e.user));
                    if (e.lat) chk("out_latency", DW'(cyc), DW'(e.cyc));
                end
            end
        end
    end
    // drives nsend beats of an nb-beat TLP; ch < 0 means the TLP must be dropped
    task automatic send_tlp(input logic [31:0] dw0, input logic [6:0] bar, input int nb, input int ch,
                            input int err_beat, input bit lat, input int nsend, output int waits);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic er;
        logic acc_err;
        waits = 0;
        acc_err = 1'b0;
        if (ch < 0 && model_cnt != 16'hFFFF) model_cnt++;
        for (int j = 0; j < nsend; j++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if (j == 0) d[31:0] = dw0;
            k = KW'($urandom);
            er = j == err_beat;
            acc_err = acc_err | er;
            bus.s_rx_tvalid = 1'b1;
            bus.s_rx_tdata = d;
            bus.s_rx_tkeep = k;
            bus.s_rx_tlast = j == nb - 1;
            bus.s_rx_tuser = {13'($urandom), j == 0 ? bar : 7'($urandom), er, 1'($urandom)};
            @(negedge clk);
            while (!bus.s_rx_tready && waits < 100) begin
                waits++;
                @(negedge clk);
            end
            if (!bus.s_rx_tready) chk("rx_accept_timeout", DW'(0), DW'(1));
            else if (ch >= 0) sb.push_back('{ch, d, k, j == 0, j == nb - 1, {acc_err, bar}, cyc + 1, lat});
            @(posedge clk);
            #1;
        end
        bus.s_rx_tvalid = 1'b0;
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int waits;
        logic [DW-1:0] held;
        vt = '{
            '{32'h4000_0004, 7'h01, 3, 2, -1},
            '{32'h4A00_0001, 7'h00, 1, 1, 0},
            '{32'h2000_0001, 7'h01, 2, 2, -1},
            '{32'h3400_0000, 7'h00, 2, -1, -1},
            '{32'h0000_0001, 7'h02, 2, -1, -1},
            '{32'h0A00_0000, 7'h00, 1, 1, -1},
            '{32'h6000_0002, 7'h03, 4, 2, 2},
            '{32'h0400_0001, 7'h01, 1, -1, -1},
            '{32'h0100_0001, 7'h01, 2, -1, -1},
            '{32'h4000_0001, 7'h00, 1, -1, -1},
            '{32'h4200_0001, 7'h01, 2, -1, -1},
            '{32'h4000_0001, 7'h40, 1, -1, -1},
            '{32'h4A00_0002, 7'h00, 3, 1, 1}
        };
        bus.s_rx_tvalid = 1'b0;
        bus.s_rx_tdata = '0;
        bus.s_rx_tkeep = '0;
        bus.s_rx_tlast = 1'b0;
        bus.s_rx_tuser = '0;
        bus.m_tready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_tready", DW'(bus.s_rx_tready), DW'(0));
        chk("rst_tvalid", DW'(bus.m_tvalid), DW'(0));
        chk("rst_sop_eop", DW'({bus.m_sop, bus.m_eop}), DW'(0));
        chk("rst_data_zero", DW'(|{bus.m_tdata, bus.m_tkeep, bus.m_tuser}), DW'(0));
        chk("rst_drop_cnt", DW'(drop_cnt), DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rx_tready", DW'(bus.s_rx_tready), DW'(1));
        @(posedge clk);
        #1;
        foreach (vt[i]) begin
            send_tlp(vt[i].dw0, vt[i].bar, vt[i].nb, vt[i].ch, vt[i].err_beat, 1'b1, vt[i].nb, waits);
            chk($sformatf("vec%0d_no_bubble", i), DW'(waits), DW'(0));
            chk($sformatf("vec%0d_drop_cnt", i), DW'(drop_cnt), DW'(model_cnt));
        end
        repeat (3) @(negedge clk);
        chk("table_drained", DW'(sb.size()), DW'(0));
        @(posedge clk);
        #1 bus.m_tready[2] = 1'b0;
        fork
            send_tlp(32'h4000_0003, 7'h01, 3, 2, -1, 1'b0, 3, waits);
            begin
                for (int t = 0; t < 20 && !bus.m_tvalid[2]; t++) @(negedge clk);
                held = bus.m_tdata[2*DW+:DW];
                for (int t = 0; t < 5; t++) begin
                    chk("stall_tvalid", DW'(bus.m_tvalid[2]), DW'(1));
                    chk("stall_data", bus.m_tdata[2*DW+:DW], held);
                    chk("stall_rx_tready", DW'(bus.s_rx_tready), DW'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1 bus.m_tready[2] = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("stall_drained", DW'(sb.size()), DW'(0));
        @(posedge clk);
        #1 force dut.cnt_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.cnt_q;
        model_cnt = 16'hFFFE;
        chk("cnt_forced", DW'(drop_cnt), DW'(16'hFFFE));
        for (int n = 0; n < 3; n++) begin
            send_tlp(32'h3000_0000, 7'h00, 1, -1, -1, 1'b1, 1, waits);
            chk($sformatf("sat_drop%0d", n), DW'(drop_cnt), DW'(model_cnt));
        end
        chk("sat_value", DW'(drop_cnt), DW'(16'hFFFF));
        send_tlp(32'h4A00_0004, 7'h00, 4, 1, -1, 1'b1, 2, waits);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rx_tready", DW'(bus.s_rx_tready), DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", DW'(bus.m_tvalid), DW'(0));
        chk("midrst_drop_cnt", DW'(drop_cnt), DW'(0));
        sb.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        send_tlp(32'h4000_0005, 7'h01, 2, 2, -1, 1'b1, 2, waits);
        chk("after_rst_drop_cnt", DW'(drop_cnt), DW'(0));
        repeat (3) @(negedge clk);
        chk("final_drained", DW'(sb.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
